// File: rtl/sramlike_bus_arbiter_if.sv
// Shared sram-like bus between the fetch/data arbiter and the bus bridge.
// One transaction: req/addr_ok address phase, then data_ok completion.
interface sramlike_bus_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sramlike_bus_arbiter.sv
// Serialises the core's single-cycle fetch and data accesses onto one sram-like
// bus, stalling the pipeline until every enabled access has completed.
module sramlike_bus_arbiter #(
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          inst_en,
  input  logic [31:0]                   inst_addr,
  output logic [31:0]                   inst_rdata,
  input  logic                          data_en,
  input  logic [3:0]                    data_wen,
  input  logic [1:0]                    data_size,
  input  logic [31:0]                   data_addr,
  input  logic [31:0]                   data_wdata,
  output logic [31:0]                   data_rdata,
  output logic                          stall,
  sramlike_bus_arbiter_if.master        bus
);

  typedef enum logic [2:0] {
    IDLE,
    D_REQ,
    D_RESP,
    I_REQ,
    I_RESP
  } state_t;

  state_t state;
  state_t nextState;

  logic iDone;
  logic dDone;
  logic iNeed;
  logic dNeed;
  logic loadData;
  logic loadInst;
  logic captureData;
  logic captureInst;

  assign iNeed = inst_en & ~iDone;
  assign dNeed = data_en & ~dDone;
  assign stall = iNeed | dNeed;

  assign bus.req = (state == D_REQ) || (state == I_REQ);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Bus handshakes are only honoured in the state that expects them
  always_comb begin
    nextState   = state;
    loadData    = 1'b0;
    loadInst    = 1'b0;
    captureData = 1'b0;
    captureInst = 1'b0;
    case (state)
      IDLE: begin
        if (dNeed && (DATA_FIRST || !iNeed)) begin
          nextState = D_REQ;
          loadData  = 1'b1;
        end else if (iNeed) begin
          nextState = I_REQ;
          loadInst  = 1'b1;
        end
      end
      D_REQ: begin
        if (bus.addr_ok) nextState = D_RESP;
      end
      D_RESP: begin
        if (bus.data_ok) begin
          nextState   = IDLE;
          captureData = 1'b1;
        end
      end
      I_REQ: begin
        if (bus.addr_ok) nextState = I_RESP;
      end
      I_RESP: begin
        if (bus.data_ok) begin
          nextState   = IDLE;
          captureInst = 1'b1;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.wr    <= 1'b0;
      bus.size  <= 2'd0;
      bus.addr  <= 32'd0;
      bus.wdata <= 32'd0;
    end else if (loadData) begin
      bus.wr    <= |data_wen;
      bus.size  <= data_size;
      bus.addr  <= data_addr;
      bus.wdata <= data_wdata;
    end else if (loadInst) begin
      bus.wr    <= 1'b0;
      bus.size  <= 2'd2;
      bus.addr  <= inst_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_rdata <= 32'd0;
      data_rdata <= 32'd0;
    end else begin
      if (captureInst) inst_rdata <= bus.rdata;
      if (captureData && !bus.wr) data_rdata <= bus.rdata;
    end
  end

  // A completion only counts while its enable is still high (flushed accesses drain silently)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iDone <= 1'b0;
      dDone <= 1'b0;
    end else if (!stall) begin
      iDone <= 1'b0;
      dDone <= 1'b0;
    end else begin
      if (captureInst) iDone <= inst_en;
      if (captureData) dDone <= data_en;
    end
  end

endmodule

// File: tb/tb_sramlike_bus_arbiter.sv
// Directed bench for sramlike_bus_arbiter: the bench plays the bus slave cycle
// by cycle and compares against hand-computed bus and core-side values.
module tb_sramlike_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_en = 1'b0;
  logic [31:0] inst_addr = 32'd0;
  logic [31:0] inst_rdata;
  logic        data_en = 1'b0;
  logic [3:0]  data_wen = 4'd0;
  logic [1:0]  data_size = 2'd0;
  logic [31:0] data_addr = 32'd0;
  logic [31:0] data_wdata = 32'd0;
  logic [31:0] data_rdata;
  logic        stall;

  int checks = 0;
  int failures = 0;

  sramlike_bus_arbiter_if busIf ();

  sramlike_bus_arbiter #(.DATA_FIRST(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .inst_en    (inst_en),
    .inst_addr  (inst_addr),
    .inst_rdata (inst_rdata),
    .data_en    (data_en),
    .data_wen   (data_wen),
    .data_size  (data_size),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_rdata (data_rdata),
    .stall      (stall),
    .bus        (busIf.master)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  // Drive this cycle's slave response, then let combinational outputs settle
  task automatic applyStimulus(input logic aOk, input logic dOk, input logic [31:0] rd);
    busIf.addr_ok = aOk;
    busIf.data_ok = dOk;
    busIf.rdata   = rd;
    #2;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic setData(input logic en, input logic [3:0] wen, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
    data_en    = en;
    data_wen   = wen;
    data_size  = sz;
    data_addr  = a;
    data_wdata = wd;
  endtask

  task automatic idleCycle();
    inst_en = 1'b0;
    data_en = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("idle_stall", 32'(stall), 32'd0);
    nextCycle();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    busIf.addr_ok = 1'b0;
    busIf.data_ok = 1'b0;
    busIf.rdata   = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_req", 32'(busIf.req), 32'd0);
    checkOutput("rst_inst_rdata", inst_rdata, 32'd0);
    checkOutput("rst_data_rdata", data_rdata, 32'd0);
    checkOutput("rst_addr", busIf.addr, 32'd0);
    rst = 1'b0;

    // Fetch only, minimum latency
    inst_en = 1'b1; inst_addr = 32'hBFC00000;
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("f_c0_stall", 32'(stall), 32'd1);
    checkOutput("f_c0_req", 32'(busIf.req), 32'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("f_c1_req", 32'(busIf.req), 32'd1);
    checkOutput("f_c1_addr", busIf.addr, 32'hBFC00000);
    checkOutput("f_c1_size", 32'(busIf.size), 32'd2);
    checkOutput("f_c1_wr", 32'(busIf.wr), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 32'h24010001);
    checkOutput("f_c2_req", 32'(busIf.req), 32'd0);
    checkOutput("f_c2_stall", 32'(stall), 32'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("f_c3_stall", 32'(stall), 32'd0);
    checkOutput("f_c3_req", 32'(busIf.req), 32'd0);
    checkOutput("f_c3_inst_rdata", inst_rdata, 32'h24010001);
    nextCycle();
    idleCycle();

    // Fetch + load, data issued first
    inst_en = 1'b1; inst_addr = 32'hBFC00004;
    setData(1'b1, 4'b0000, 2'd2, 32'h80000010, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("fl_c0_stall", 32'(stall), 32'd1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("fl_c1_req", 32'(busIf.req), 32'd1);
    checkOutput("fl_c1_addr", busIf.addr, 32'h80000010);
    checkOutput("fl_c1_wr", 32'(busIf.wr), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 32'hDEADBEEF);
    checkOutput("fl_c2_stall", 32'(stall), 32'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("fl_c3_stall", 32'(stall), 32'd1);
    checkOutput("fl_c3_req", 32'(busIf.req), 32'd0);
    checkOutput("fl_c3_data_rdata", data_rdata, 32'hDEADBEEF);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("fl_c4_req", 32'(busIf.req), 32'd1);
    checkOutput("fl_c4_addr", busIf.addr, 32'hBFC00004);
    checkOutput("fl_c4_size", 32'(busIf.size), 32'd2);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 32'h3C1D8000);
    checkOutput("fl_c5_stall", 32'(stall), 32'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("fl_c6_stall", 32'(stall), 32'd0);
    checkOutput("fl_c6_inst_rdata", inst_rdata, 32'h3C1D8000);
    checkOutput("fl_c6_data_rdata", data_rdata, 32'hDEADBEEF);
    nextCycle();
    idleCycle();

    // Byte store with a slave that holds off addr_ok for 3 cycles
    setData(1'b1, 4'b0010, 2'd0, 32'h80000001, 32'h0000AB00);
    applyStimulus(1'b0, 1'b0, 32'd0);
    nextCycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 32'd0);
      checkOutput($sformatf("st_wait%0d_req", i), 32'(busIf.req), 32'd1);
      checkOutput($sformatf("st_wait%0d_addr", i), busIf.addr, 32'h80000001);
      checkOutput($sformatf("st_wait%0d_wr", i), 32'(busIf.wr), 32'd1);
      checkOutput($sformatf("st_wait%0d_size", i), 32'(busIf.size), 32'd0);
      checkOutput($sformatf("st_wait%0d_wdata", i), busIf.wdata, 32'h0000AB00);
      nextCycle();
    end
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("st_accept_req", 32'(busIf.req), 32'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 32'hFFFFFFFF);
    checkOutput("st_resp_req", 32'(busIf.req), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("st_done_stall", 32'(stall), 32'd0);
    checkOutput("st_data_rdata", data_rdata, 32'hDEADBEEF);
    nextCycle();
    idleCycle();

    // Slow slave with a spurious data_ok during the address phase
    setData(1'b1, 4'b0000, 2'd2, 32'h80000020, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 32'h11111111);
    checkOutput("ss_spur_req", 32'(busIf.req), 32'd1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("ss_accept_req", 32'(busIf.req), 32'd1);
    checkOutput("ss_accept_data_rdata", data_rdata, 32'hDEADBEEF);
    nextCycle();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h22222222);
      checkOutput($sformatf("ss_wait%0d_stall", i), 32'(stall), 32'd1);
      checkOutput($sformatf("ss_wait%0d_req", i), 32'(busIf.req), 32'd0);
      checkOutput($sformatf("ss_wait%0d_data_rdata", i), data_rdata, 32'hDEADBEEF);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b1, 32'hCAFEF00D);
    checkOutput("ss_resp_stall", 32'(stall), 32'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("ss_done_stall", 32'(stall), 32'd0);
    checkOutput("ss_data_rdata", data_rdata, 32'hCAFEF00D);
    nextCycle();
    idleCycle();

    // Done flags clear after one unstalled cycle; the next fetch starts fresh
    inst_en = 1'b1; inst_addr = 32'hBFC00000;
    applyStimulus(1'b0, 1'b0, 32'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 32'h11112222);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("dc_c3_stall", 32'(stall), 32'd0);
    checkOutput("dc_c3_inst_rdata", inst_rdata, 32'h11112222);
    nextCycle();
    inst_addr = 32'hBFC00008;
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("dc_c4_stall", 32'(stall), 32'd1);
    checkOutput("dc_c4_req", 32'(busIf.req), 32'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("dc_c5_req", 32'(busIf.req), 32'd1);
    checkOutput("dc_c5_addr", busIf.addr, 32'hBFC00008);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 32'h33334444);
    checkOutput("dc_c6_inst_rdata", inst_rdata, 32'h11112222);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("dc_c7_stall", 32'(stall), 32'd0);
    checkOutput("dc_c7_inst_rdata", inst_rdata, 32'h33334444);
    nextCycle();
    idleCycle();

    // Asynchronous reset while waiting for data_ok
    inst_en = 1'b1; inst_addr = 32'hBFC0000C;
    applyStimulus(1'b0, 1'b0, 32'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("ar_resp_req", 32'(busIf.req), 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("ar_req", 32'(busIf.req), 32'd0);
    checkOutput("ar_addr", busIf.addr, 32'd0);
    checkOutput("ar_size", 32'(busIf.size), 32'd0);
    checkOutput("ar_inst_rdata", inst_rdata, 32'd0);
    checkOutput("ar_data_rdata", data_rdata, 32'd0);
    nextCycle();
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("ar_rel_req", 32'(busIf.req), 32'd0);
    checkOutput("ar_rel_stall", 32'(stall), 32'd1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("ar_r1_req", 32'(busIf.req), 32'd1);
    checkOutput("ar_r1_addr", busIf.addr, 32'hBFC0000C);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 32'h55667788);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("ar_r3_stall", 32'(stall), 32'd0);
    checkOutput("ar_r3_inst_rdata", inst_rdata, 32'h55667788);
    nextCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
